// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants and helpers shared by the JPEG block buffers.
// Contents:
//   BLK_COEFS     coefficients per 8x8 block
//   ZZ_TO_RASTER  zigzag scan index -> natural (raster) index. The encoder's
//                 zigzag buffer uses the same table.
//   zz_to_raster  lookup wrapper around ZZ_TO_RASTER
package jpeg_pkg;

    localparam int BLK_COEFS = 32'sd64;

    typedef logic [5:0] coef_idx_t;
    typedef logic [2:0] row_idx_t;

    localparam coef_idx_t ZZ_TO_RASTER [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic coef_idx_t zz_to_raster(input coef_idx_t k);
        return ZZ_TO_RASTER[k];
    endfunction

endpackage

// File: rtl/dezigzag_buffer_64x8bit_if.sv
// dezigzag_buffer_64x8bit_if: handshake bundle of the inverse-zigzag buffer.
// Coefficient side: coef_valid/coef_ready, coef_data (8b), coef_eob.
// Row side:         row_valid/row_ready, row_data (64b), row_index (3b), row_last.
// Modports: slave = the buffer itself, master = the producer/consumer around it.
interface dezigzag_buffer_64x8bit_if;

    logic        coef_valid;
    logic        coef_ready;
    logic [7:0]  coef_data;
    logic        coef_eob;
    logic        row_valid;
    logic        row_ready;
    logic [63:0] row_data;
    logic [2:0]  row_index;
    logic        row_last;

    modport slave (
        input  coef_valid, coef_data, coef_eob, row_ready,
        output coef_ready, row_valid, row_data, row_index, row_last
    );

    modport master (
        output coef_valid, coef_data, coef_eob, row_ready,
        input  coef_ready, row_valid, row_data, row_index, row_last
    );

endinterface

// File: rtl/dezigzag_bank.sv
// dezigzag_bank: one 64x8 coefficient store with a per-position written mask.
// Ports:
//   clock, reset_n  clock and async active-low reset (mask only)
//   wr_en/wr_addr/wr_data  write one coefficient at a raster address
//   clr             synchronous clear of the whole mask (bank release)
//   rd_row          raster row to present
//   rd_data         row rd_row, column c at [8c+7:8c]; unwritten positions read 0
module dezigzag_bank
    import jpeg_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_en,
    input  coef_idx_t   wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clr,
    input  row_idx_t    rd_row,
    output logic [63:0] rd_data
);

    // Data is deliberately left unreset: the mask decides what is visible,
    // so stale bytes from an earlier or aborted block never leak out.
    logic [7:0]           mem_r [0:BLK_COEFS-1];
    logic [BLK_COEFS-1:0] mask_r;
    logic [63:0]          rd_data_s;

    // Coefficient data write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Written-mask: set on write, cleared wholesale when the bank is released
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= '0;
        end else if (clr) begin
            mask_r <= '0;
        end else if (wr_en) begin
            mask_r[wr_addr] <= 1'b1;
        end
    end

    // Masked row read: positions never written in this block read as zero,
    // which is what implements end-of-block zero fill
    always_comb begin
        rd_data_s = 64'd0;
        for (int c = 0; c < 8; c++) begin
            if (mask_r[{rd_row, 3'(c)}]) begin
                rd_data_s[8*c +: 8] = mem_r[{rd_row, 3'(c)}];
            end else begin
                rd_data_s[8*c +: 8] = 8'd0;
            end
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/dezigzag_buffer_64x8bit.sv
// dezigzag_buffer_64x8bit: inverse-zigzag ping-pong block buffer.
// Accepts one coefficient per handshake in zigzag order, stores it at its
// raster position in the current write bank, and emits completed blocks as
// eight 64-bit raster rows. coef_eob closes a block early; the remaining
// positions read as zero.
// Ports:
//   clock    rising-edge clock
//   reset_n  async active-low reset
//   bus      dezigzag_buffer_64x8bit_if.slave (coef_* input stream, row_* output stream)
module dezigzag_buffer_64x8bit
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH = 32'sd8,
    parameter int DEPTH      = 32'sd64
)
(
    input  logic                       clock,
    input  logic                       reset_n,
    dezigzag_buffer_64x8bit_if.slave   bus
);

    localparam coef_idx_t LAST_K = 6'(DEPTH - 1);

    logic            wr_bank_r;
    coef_idx_t       wr_k_r;
    logic [1:0]      full_r;
    logic            rd_bank_r;
    row_idx_t        rd_row_r;

    logic            accept_s;
    logic            wr_data_en_s;
    logic            close_s;
    logic            pop_s;
    logic            release_s;
    coef_idx_t       wr_addr_s;
    logic [1:0]      bank_wr_en_s;
    logic [1:0]      bank_clr_s;
    logic [1:0]      full_next_s;
    logic [DATA_WIDTH-1:0] coef_data_s;
    logic [63:0]     bank0_rd_s;
    logic [63:0]     bank1_rd_s;

    assign coef_data_s = bus.coef_data;

    // Handshake decode and per-bank strobes. A bank can only be closed while
    // empty and only released while full, so close and release in the same
    // cycle always hit different banks.
    always_comb begin
        accept_s     = bus.coef_valid & ~full_r[wr_bank_r];
        wr_data_en_s = accept_s & ~bus.coef_eob;
        close_s      = accept_s & (bus.coef_eob | (wr_k_r == LAST_K));
        pop_s        = full_r[rd_bank_r] & bus.row_ready;
        release_s    = pop_s & (rd_row_r == 3'd7);
        wr_addr_s    = zz_to_raster(wr_k_r);

        bank_wr_en_s = 2'b00;
        bank_clr_s   = 2'b00;
        bank_wr_en_s[wr_bank_r] = wr_data_en_s;
        bank_clr_s[rd_bank_r]   = release_s;

        full_next_s = full_r;
        if (close_s) begin
            full_next_s[wr_bank_r] = 1'b1;
        end else begin
            full_next_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (release_s) begin
            full_next_s[rd_bank_r] = 1'b0;
        end else begin
            full_next_s[rd_bank_r] = full_next_s[rd_bank_r];
        end
    end

    // Write pointer: zigzag index within the block and the bank being filled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_r <= 1'b0;
            wr_k_r    <= 6'd0;
        end else if (close_s) begin
            wr_bank_r <= ~wr_bank_r;
            wr_k_r    <= 6'd0;
        end else if (accept_s) begin
            wr_k_r    <= wr_k_r + 6'd1;
        end
    end

    // Read pointer: row within the block and the bank being drained
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank_r <= 1'b0;
            rd_row_r  <= 3'd0;
        end else if (release_s) begin
            rd_bank_r <= ~rd_bank_r;
            rd_row_r  <= 3'd0;
        end else if (pop_s) begin
            rd_row_r  <= rd_row_r + 3'd1;
        end
    end

    // Per-bank full flags, updated independently so close and release can coincide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_next_s;
        end
    end

    dezigzag_bank u_bank0 (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (bank_wr_en_s[0]),
        .wr_addr (wr_addr_s),
        .wr_data (coef_data_s),
        .clr     (bank_clr_s[0]),
        .rd_row  (rd_row_r),
        .rd_data (bank0_rd_s)
    );

    dezigzag_bank u_bank1 (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (bank_wr_en_s[1]),
        .wr_addr (wr_addr_s),
        .wr_data (coef_data_s),
        .clr     (bank_clr_s[1]),
        .rd_row  (rd_row_r),
        .rd_data (bank1_rd_s)
    );

    // Outputs come straight from registers (no coef -> row combinational path)
    assign bus.coef_ready = ~full_r[wr_bank_r];
    assign bus.row_valid  = full_r[rd_bank_r];
    assign bus.row_data   = rd_bank_r ? bank1_rd_s : bank0_rd_s;
    assign bus.row_index  = rd_row_r;
    assign bus.row_last   = (rd_row_r == 3'd7);

endmodule

// File: doc/dezigzag_buffer_64x8bit.md
# dezigzag_buffer_64x8bit

Inverse-zigzag block buffer for the JPEG decode path. It accepts one quantized coefficient per handshake in zigzag scan order, the order the Huffman decoder produces. It reorders the coefficients into raster order in a two-bank ping-pong store and emits each completed 8×8 block as eight 64-bit rows for the dequantize/IDCT stages. It is the decode-side counterpart of `databuffer_zigzag64x8bit` and supports JPEG end-of-block zero-fill.

## Interface
- `DATA_WIDTH`, 8, coefficient width in bits; only 8 is supported.
- `DEPTH`, 64, coefficients per block; only 64 is supported.

- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `coef_valid`  in  1  `coef_data`/`coef_eob` are valid.
- `coef_ready`  out  1  buffer can accept a beat.
- `coef_data`  in  8  signed coefficient, zigzag index k = internal write counter.
- `coef_eob`  in  1  end-of-block marker, qualified by `coef_valid`. On this beat `coef_data` is ignored and positions k..63 read as zero.
- `row_valid`  out  1  `row_data` holds a valid raster row.
- `row_ready`  in  1  consumer accepts the row.
- `row_data`  out  64  raster row; column c at bits [8c+7:8c].
- `row_index`  out  3  row number 0..7.
- `row_last`  out  1  high when `row_index`==7.

## Operation
- **Storage.** Two banks, each holding 64×8 data (not reset) plus a 64-bit written-mask (reset). A raster position reads as its data if its mask bit is set, otherwise as 0.
- **Write side.** `wr_bank` (1b), `wr_k` (6b), and `full[1:0]`.
  - `coef_ready` = !`full[wr_bank]`.
  - Accepted non-EOB beat: store `coef_data` at raster address `ZZ_TO_RASTER[wr_k]` in `wr_bank`, set that mask bit, `wr_k`++.
  - The block closes on an accepted beat with `wr_k`==63, or on any accepted EOB beat.
  - On close: set `full[wr_bank]`, `wr_k`←0, `wr_bank` toggles.
- **Read side.** `rd_bank` (1b) and `rd_row` (3b).
  - `row_valid` = `full[rd_bank]`.
  - `row_data` = masked row `rd_row` of `rd_bank`.
  - On `row_valid` && `row_ready`: `rd_row`++.
  - If `rd_row`==7 at that handshake: clear `full[rd_bank]`, clear its mask, `rd_row`←0, `rd_bank` toggles.
- **Boundary cases.**
  - Both banks full: `coef_ready`=0 and write stalls.
  - Close and release in the same cycle: both take effect, with independent per-bank flags.
  - EOB at k=0: the whole block is zero.
  - EOB at k=63: position 63 is zero.
  - Beats with `coef_valid`=0 change nothing.
  - `coef_eob` is ignored when `coef_valid`=0.

## Timing
- **Reset values.** `coef_ready`=1, `row_valid`=0, `row_data`=0, `row_index`=0, `row_last`=0. All counters, masks and full flags are 0; both bank pointers are 0.
- **Reset mid-block.** Partial data is discarded. Residual storage is invisible because the masks are cleared.
- **Handshakes.** Standard valid/ready on both sides. The input accepts at most 1 beat/cycle; the output emits at most 1 row/cycle.
- **Latency.** Block closes at the edge of cycle N, so `row_valid`=1 with `row_index`=0 from cycle N+1. Outputs are combinational from registers; there is no input-to-output combinational path.
- **Throughput.** With `row_ready`=1, 64 in-cycles and 8 out-cycles per block. Streaming is continuous with no bubbles.
- **Output stability.** While `row_valid` && !`row_ready`, `row_data`, `row_index` and `row_last` hold stable.
- **Ready after release.** A bank released at edge M makes `coef_ready` high from cycle M+1.

## Structure
- Shared package `jpeg_pkg`:
  - `ZZ_TO_RASTER[0:63]`, the standard JPEG zigzag-to-natural table, shared with the encoder's zigzag buffer. Checkpoints: 0→0, 1→1, 2→8, 3→16, 4→9, 5→2, 60→47, 61→55, 62→62, 63→63.
  - `BLK_COEFS`=64.
- One sub-module, `dezigzag_bank`: one 64×8 store with mask, write port, row read port and synchronous mask clear. Instantiate it twice.
- Pointer and handshake logic stays in the top module.

## Test plan
- **Full block, no EOB.** Send 64 beats with data=k+1, `row_ready`=1. Expect row 0 = {29,28,16,15,7,6,2,1} (MSB→LSB), row 1 [7:0]=3, row 7 [63:56]=64. `row_index` runs 0..7 and `row_last` is high only on row 7.
- **Early EOB.** Send 10, 20, 30, then EOB. Expect row 0 [7:0]=10, [15:8]=20, row 1 [7:0]=30, all other bytes 0, `row_valid` on the cycle after the EOB.
- **Ping-pong fill.** Hold `row_ready`=0 and drive 3 blocks. Expect `coef_ready`=0 after 128 accepted beats. Expect block 1 rows out first when `row_ready` rises, and the third block resuming 1 cycle after block 1's row 7 handshake.
- **Backpressure.** Toggle `row_ready` randomly. Expect row data/index stable while stalled, no row lost or duplicated, and exactly 8 handshakes per block.
- **Simultaneous close and release.** Close block 2 on the same cycle as the row 7 handshake of block 1. Expect both banks' flags correct, `coef_ready`=1 next cycle, and block 2 rows intact.
- **Reset mid-block.** Send 30 beats, pulse `reset_n` low, then send an EOB-only block. Expect all-zero rows and no residue from the aborted block.
